bcd2bin_seq: RTL
================

// Module: bcd2bin_seq
// PURPOSE
//  Sequential BCD-to-binary converter; the inverse of the B2BCD display path.
//  Converts an NDIG-digit packed BCD word to an unsigned binary value of BW bits.
//  Uses one multiply-by-10 accumulate per clock, most significant digit first.
//  Feeds keypad/setpoint entry (e.g. 4 digits "3123") back into the 12-bit fuzzy datapath.
// PARAMETERS
//  NDIG  4   number of BCD digits (>=1)
//  BW    12  output binary width; values above 2**BW-1 saturate and flag ovf
// PORTS
//  clk     in   1       rising-edge clock
//  rst     in   1       asynchronous reset, active high
//  start   in   1       request conversion; sampled only in IDLE
//  bcd_in  in   4*NDIG  packed BCD; bits[3:0] = units digit, top nibble = MSD
//  busy    out  1       high while a conversion is in progress
//  done    out  1       one-cycle pulse when bin/ovf/err are updated
//  bin     out  BW      binary result; holds until the next done
//  ovf     out  1       result exceeded 2**BW-1 (bin = all ones)
//  err     out  1       an input nibble was > 9 (bin = 0, ovf = 0)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; busy, done, ovf, err = 0; bin = 0; internal regs = 0.
//  Internal regs: dig_sr (4*NDIG), acc (4*NDIG wide, since 10**NDIG < 16**NDIG),
//   cnt (counts 0..NDIG-1), bad (1 bit).
//  FSM states: IDLE, CONV.
//  IDLE: done=0 unless it is the pulse cycle.
//   On start=1 at edge E0: dig_sr<=bcd_in; acc<=0; cnt<=0; busy<=1;
//   bad<=(any nibble>9); state<=CONV.
//  CONV, each edge: nxt = acc*10 + dig_sr[top nibble]; acc<=nxt;
//   dig_sr<=dig_sr<<4; cnt<=cnt+1.
//  At the edge where cnt==NDIG-1 (edge E0+NDIG):
//   state<=IDLE; busy<=0; done<=1.
//   If bad: bin<=0, err<=1, ovf<=0.
//   Else if nxt > 2**BW-1: bin<={BW{1}}, ovf<=1, err<=0.
//   Else: bin<=nxt[BW-1:0], ovf<=0, err<=0.
//  Timing: done is high in the cycle after edge E0+NDIG, i.e. NDIG+1 clocks after start is sampled.
//   done deasserts on the next edge.
//   busy is high from E0 to E0+NDIG. Latency is fixed, including the error case.
//  The error nibble is still accumulated; its value is discarded.
//   The conversion runs to completion for constant timing.
//  start while busy=1: ignored, with no queueing. start held high across done:
//   a new conversion begins at the first edge in IDLE (the edge after done rises).
//  bcd_in is only sampled at E0; changes during CONV have no effect.
//  Reset during CONV: conversion is aborted; no done pulse; bin/ovf/err return to 0.
//  Arithmetic: acc*10 is computed as (acc<<3)+(acc<<1) in 4*NDIG+4 bits with no truncation
//   before the overflow compare.
// TESTING
//  1 Reset, NDIG=4, BW=12, bcd_in=16'h0412, start 1 clk
//    -> busy 4 clks, done on clk 5, bin=412, ovf=0, err=0.
//  2 bcd_in=16'h3123 -> bin=3123 (0xC33); then 16'h4095 -> bin=4095, ovf=0.
//  3 bcd_in=16'h9999: BW=12 -> bin=0xFFF, ovf=1; BW=14 instance -> bin=9999, ovf=0.
//  4 bcd_in=16'h41A2 -> err=1, bin=0, ovf=0, done still at clk 5;
//    next 16'h0000 -> bin=0, err=0.
//  5 Pulse start again 2 clks after a start, with a different bcd_in
//    -> ignored; single done with the first result.
//    Hold start high -> back-to-back conversions every 5 clks.
//  6 Assert rst mid-CONV (after 2 clks) -> busy/done/bin/ovf/err = 0 immediately;
//    no done pulse; the next conversion is correct.

Source files
------------

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter, one digit per clock, MSD first.
// Saturates above 2**BW-1 (ovf) and flags non-decimal nibbles (err).
module bcd2bin_seq #(
  parameter int NDIG = 4,
  parameter int BW   = 12
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [4*NDIG-1:0] i_bcd_in,
  output logic              o_busy,
  output logic              o_done,
  output logic [BW-1:0]     o_bin,
  output logic              o_ovf,
  output logic              o_err
);

  localparam int DW = 4 * NDIG;
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int XW = (DW + 4 > BW) ? DW + 4 : BW + 1;
  localparam logic [XW-1:0] MAXV = {XW{1'b1}} >> (XW - BW);

  typedef enum logic {
    S_IDLE,
    S_CONV
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [DW-1:0] r_dig_sr;
  logic [DW-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_bad;
  logic          r_done;
  logic [BW-1:0] r_bin;
  logic          r_ovf;
  logic          r_err;

  logic          w_bad_in;
  logic          w_load;
  logic          w_last;
  logic [DW+3:0] w_ext;
  logic [DW+3:0] w_nxt;
  logic [XW-1:0] w_nxt_x;

  // Flag any input nibble that is not a decimal digit.
  always_comb begin
    w_bad_in = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (i_bcd_in[4*i +: 4] > 4'd9) w_bad_in = 1'b1;
    end
  end

  // acc*10 + next digit, kept wide so the overflow compare sees every bit.
  always_comb begin
    w_ext   = {4'b0000, r_acc};
    w_nxt   = (w_ext << 3) + (w_ext << 1)
            + {{DW{1'b0}}, r_dig_sr[DW-1 -: 4]};
    w_nxt_x = XW'(w_nxt);
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic plus load/finish strobes for the datapath.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_last = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_load = 1'b1;
          w_next = S_CONV;
        end
      end
      S_CONV: begin
        if (r_cnt == CW'(NDIG - 1)) begin
          w_last = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Digit shifter, accumulator and result registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dig_sr <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_bad    <= 1'b0;
      r_done   <= 1'b0;
      r_bin    <= '0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_load) begin
        r_dig_sr <= i_bcd_in;
        r_acc    <= '0;
        r_cnt    <= '0;
        r_bad    <= w_bad_in;
      end else if (r_state == S_CONV) begin
        r_acc    <= w_nxt[DW-1:0];
        r_dig_sr <= r_dig_sr << 4;
        r_cnt    <= r_cnt + CW'(1);
        if (w_last) begin
          if (r_bad) begin
            r_bin <= '0;
            r_err <= 1'b1;
            r_ovf <= 1'b0;
          end else if (w_nxt_x > MAXV) begin
            r_bin <= {BW{1'b1}};
            r_ovf <= 1'b1;
            r_err <= 1'b0;
          end else begin
            r_bin <= w_nxt_x[BW-1:0];
            r_ovf <= 1'b0;
            r_err <= 1'b0;
          end
        end
      end
    end
  end

  assign o_busy = (r_state == S_CONV);
  assign o_done = r_done;
  assign o_bin  = r_bin;
  assign o_ovf  = r_ovf;
  assign o_err  = r_err;

endmodule
